// File: rtl/pattern_sequencer.sv
// Frame-synchronous test-pattern selector: samples buttons at each VBlank start, applies
// press/auto-repeat/home rules, and drives a wrapping pattern index plus mute and OSD windows.
module pattern_sequencer #(
  parameter int NUM_PATTERNS = 8,
  parameter int REPEAT_DELAY = 30,
  parameter int REPEAT_RATE  = 6,
  parameter int MUTE_FRAMES  = 2,
  parameter int OSD_FRAMES   = 120,
  parameter int PW           = $clog2(NUM_PATTERNS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vblank,
  input  logic          btn_next,
  input  logic          btn_prev,
  input  logic          btn_home,
  output logic [PW-1:0] pattern,
  output logic          pattern_changed,
  output logic          mute,
  output logic          osd_show
);

  localparam int HW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
  localparam int MW = $clog2(MUTE_FRAMES + 1);
  localparam int OW = $clog2(OSD_FRAMES + 1);

  localparam logic [HW-1:0] DELAY    = HW'(REPEAT_DELAY);
  localparam logic [HW-1:0] HOLD_MAX = HW'(REPEAT_DELAY + REPEAT_RATE);
  localparam logic [PW-1:0] LAST     = PW'(NUM_PATTERNS - 1);
  localparam logic [MW-1:0] MUTE_LD  = MW'(MUTE_FRAMES);
  localparam logic [OW-1:0] OSD_LD   = OW'(OSD_FRAMES);

  typedef enum logic [1:0] {DIR_NONE, DIR_NEXT, DIR_PREV} dir_t;

  logic          vblank_q;
  logic          home_q,   home_d;
  dir_t          held_dir, held_dir_d;
  logic [HW-1:0] hold_cnt, hold_cnt_d;
  logic [PW-1:0] pattern_d;
  logic          changed;
  logic [MW-1:0] mute_cnt, mute_cnt_d;
  logic [OW-1:0] osd_cnt,  osd_cnt_d;

  logic          tick;
  logic          step;
  dir_t          req;
  logic [HW-1:0] hold_inc;

  assign tick = vblank & ~vblank_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      vblank_q        <= 1'b0;
      home_q          <= 1'b0;
      held_dir        <= DIR_NONE;
      hold_cnt        <= '0;
      pattern         <= '0;
      pattern_changed <= 1'b0;
      mute_cnt        <= '0;
      osd_cnt         <= OSD_LD;
    end else begin
      vblank_q        <= vblank;
      home_q          <= home_d;
      held_dir        <= held_dir_d;
      hold_cnt        <= hold_cnt_d;
      pattern         <= pattern_d;
      pattern_changed <= changed;
      mute_cnt        <= mute_cnt_d;
      osd_cnt         <= osd_cnt_d;
    end
  end

  always_comb begin
    home_d     = home_q;
    held_dir_d = held_dir;
    hold_cnt_d = hold_cnt;
    pattern_d  = pattern;
    mute_cnt_d = mute_cnt;
    osd_cnt_d  = osd_cnt;
    changed    = 1'b0;
    step       = 1'b0;
    req        = DIR_NONE;
    hold_inc   = (hold_cnt == HOLD_MAX) ? HOLD_MAX : hold_cnt + HW'(1);

    if (tick) begin
      if (btn_home) begin
        // Home acts once per press; holding it masks the direction buttons.
        home_d     = 1'b1;
        held_dir_d = DIR_NONE;
        hold_cnt_d = '0;
        if (!home_q && pattern != '0) begin
          pattern_d = '0;
          changed   = 1'b1;
        end
      end else begin
        home_d = 1'b0;
        if (btn_next ^ btn_prev) req = btn_next ? DIR_NEXT : DIR_PREV;

        if (req == DIR_NONE) begin
          held_dir_d = DIR_NONE;
          hold_cnt_d = '0;
        end else if (req != held_dir) begin
          held_dir_d = req;
          hold_cnt_d = HW'(1);
          step       = 1'b1;
        end else if (hold_inc == HOLD_MAX) begin
          // Reload to the first-repeat point so steps recur every REPEAT_RATE ticks.
          hold_cnt_d = DELAY;
          step       = 1'b1;
        end else begin
          hold_cnt_d = hold_inc;
          step       = (hold_inc == DELAY);
        end

        if (step) begin
          changed = 1'b1;
          if (req == DIR_NEXT) pattern_d = (pattern == LAST) ? '0 : pattern + PW'(1);
          else                 pattern_d = (pattern == '0) ? LAST : pattern - PW'(1);
        end
      end

      if (changed) begin
        mute_cnt_d = MUTE_LD;
        osd_cnt_d  = OSD_LD;
      end else begin
        if (mute_cnt != '0) mute_cnt_d = mute_cnt - MW'(1);
        if (osd_cnt != '0)  osd_cnt_d  = osd_cnt - OW'(1);
      end
    end
  end

  assign mute     = (mute_cnt != '0);
  assign osd_show = (osd_cnt != '0);

endmodule

// File: tb/tb_pattern_sequencer.sv
// Randomized/directed bench: a frame-level reference model queues per-tick expectations,
// and an independent monitor compares them against the DUT after every frame tick.
module tb_pattern_sequencer;

  localparam int NP = 8, RD = 30, RR = 6, MF = 2, OF = 120;
  localparam int PW = $clog2(NP);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          vblank = 1'b0;
  logic          btn_next = 1'b0, btn_prev = 1'b0, btn_home = 1'b0;
  logic [PW-1:0] pattern;
  logic          pattern_changed, mute, osd_show;

  pattern_sequencer #(
    .NUM_PATTERNS(NP), .REPEAT_DELAY(RD), .REPEAT_RATE(RR),
    .MUTE_FRAMES(MF), .OSD_FRAMES(OF), .PW(PW)
  ) dut (
    .clk(clk), .reset(reset), .vblank(vblank),
    .btn_next(btn_next), .btn_prev(btn_prev), .btn_home(btn_home),
    .pattern(pattern), .pattern_changed(pattern_changed),
    .mute(mute), .osd_show(osd_show)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit changed;
    int pat;
    bit mute;
    bit osd;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, got, want, $time);
  endtask

  // Reference model: held-tick count is kept unbounded and the repeat rule is plain arithmetic.
  int m_pat, m_dir, m_ticks, m_mute, m_osd;
  bit m_home_prev;

  task automatic model_reset();
    m_pat = 0; m_dir = 0; m_ticks = 0; m_mute = 0; m_osd = OF; m_home_prev = 0;
  endtask

  task automatic model_tick(input bit n, input bit p, input bit h, output exp_t e);
    bit chg = 0;
    int dir;
    bit step = 0;
    if (h) begin
      if (!m_home_prev && m_pat != 0) begin m_pat = 0; chg = 1; end
      m_home_prev = 1; m_dir = 0; m_ticks = 0;
    end else begin
      m_home_prev = 0;
      dir = (n && !p) ? 1 : (p && !n) ? -1 : 0;
      if (dir == 0) begin
        m_dir = 0; m_ticks = 0;
      end else if (dir != m_dir) begin
        m_dir = dir; m_ticks = 1; step = 1;
      end else begin
        m_ticks++;
        step = (m_ticks == RD) || (m_ticks > RD && (m_ticks - RD) % RR == 0);
      end
      if (step) begin m_pat = (m_pat + dir + NP) % NP; chg = 1; end
    end
    if (chg) begin m_mute = MF; m_osd = OF; end
    else begin
      if (m_mute > 0) m_mute--;
      if (m_osd > 0)  m_osd--;
    end
    e.changed = chg; e.pat = m_pat; e.mute = (m_mute > 0); e.osd = (m_osd > 0);
  endtask

  // Monitor: tracks tick occurrence independently, then checks outputs half a cycle later.
  logic vb_prev = 1'b0, tick_seen = 1'b0;
  always @(posedge clk) begin
    tick_seen <= vblank && !vb_prev && !reset;
    vb_prev   <= reset ? 1'b0 : vblank;
  end

  always @(negedge clk) begin
    exp_t e;
    if (tick_seen) begin
      if (exp_q.size() == 0) begin
        check("unexpected_tick", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("pattern_changed", int'(pattern_changed), int'(e.changed));
        check("pattern", int'(pattern), e.pat);
        check("mute", int'(mute), int'(e.mute));
        check("osd_show", int'(osd_show), int'(e.osd));
      end
    end else if (!reset) begin
      check("stray_pulse", int'(pattern_changed), 0);
    end
  end

  task automatic check_reset_state();
    check("rst_pattern", int'(pattern), 0);
    check("rst_changed", int'(pattern_changed), 0);
    check("rst_mute", int'(mute), 0);
    check("rst_osd", int'(osd_show), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; vblank = 1'b0;
    btn_next = 1'b0; btn_prev = 1'b0; btn_home = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_state();
    reset = 1'b0;
    model_reset();
  endtask

  // One frame: active video with optional mid-frame glitch, then vblank for vb_len cycles.
  task automatic do_frame(input bit n, input bit p, input bit h,
                          input int vb_len = 2, input bit glitch = 0);
    exp_t e;
    @(negedge clk);
    vblank = 1'b0; btn_next = n; btn_prev = p; btn_home = h;
    @(negedge clk);
    if (glitch) begin
      btn_next = 1'($urandom); btn_prev = 1'($urandom); btn_home = 1'($urandom);
    end
    @(negedge clk);
    btn_next = n; btn_prev = p; btn_home = h;
    @(negedge clk);
    model_tick(n, p, h, e);
    exp_q.push_back(e);
    vblank = 1'b1;
    repeat (vb_len) @(negedge clk);
  endtask

  task automatic frames(input int cnt, input bit n, input bit p, input bit h);
    for (int i = 0; i < cnt; i++) do_frame(n, p, h);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset();

    // Single step then mute/osd windows.
    do_frame(1, 0, 0);
    frames(3, 0, 0, 0);

    // Wrap both ways: 1 -> 0 -> 7 -> 0 -> 7.
    do_frame(0, 1, 0); do_frame(0, 0, 0);
    do_frame(0, 1, 0); do_frame(0, 0, 0);
    do_frame(1, 0, 0); do_frame(0, 0, 0);
    do_frame(0, 1, 0); do_frame(0, 0, 0);

    // Home to 0, then auto-repeat prev for 45 ticks.
    do_frame(0, 0, 1); do_frame(0, 0, 0);
    frames(45, 0, 1, 0);
    do_frame(0, 0, 0);

    // next+prev conflict, then home with next added, home again at 0.
    frames(10, 1, 1, 0);
    do_frame(1, 0, 0); do_frame(0, 0, 0);
    do_frame(0, 0, 1);
    frames(3, 1, 0, 1);
    do_frame(0, 0, 0);
    do_frame(0, 0, 1); do_frame(0, 0, 0);

    // Frozen vblank and direct next->prev switch.
    do_frame(1, 0, 0, 20);
    do_frame(0, 1, 0);
    do_frame(0, 0, 0);

    // OSD window: change on tick 100 after reset keeps osd up until tick 220.
    do_reset();
    frames(99, 0, 0, 0);
    do_frame(1, 0, 0);
    frames(125, 0, 0, 0);

    // Reset colliding with a tick while next is held.
    do_frame(1, 0, 0);
    @(negedge clk);
    vblank = 1'b0; btn_next = 1'b1;
    repeat (3) @(negedge clk);
    vblank = 1'b1; reset = 1'b1;
    @(negedge clk);
    vblank = 1'b0; reset = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset_state();
    do_frame(1, 0, 0);
    do_frame(0, 0, 0);

    // Randomized frames, with buttons held in runs so repeats occur.
    for (int i = 0; i < 40; i++) begin
      bit n = 1'($urandom_range(0, 1));
      bit p = 1'($urandom_range(0, 1));
      bit h = ($urandom_range(0, 7) == 0);
      int run = $urandom_range(1, 40);
      for (int j = 0; j < run; j++)
        do_frame(n, p, h, $urandom_range(1, 4), 1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
